dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port data memory.
//  Requester 0 = MIPS32 core load/store path; requester 1 = loader/debug port (coin table, amount, results).
//  Grants the memory one transaction at a time and generates the memory strobes.
//  Returns read data and write acknowledges with fixed latency.
//  Supports a short atomic lock for read-modify-write.
// PARAMETERS
//  AW        32  address width (byte address)
//  DW        32  data width
//  LOCK_MAX  4   max consecutive locked grants to one requester while the other waits
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   2      request per requester; hold until gnt
//  we         in   2      1 = write, 0 = read; sampled at gnt
//  lock       in   2      keep ownership for next access; sampled at gnt
//  addr       in   2*AW   byte addresses, {addr1,addr0}; sampled at gnt
//  wdata      in   2*DW   write data, {wdata1,wdata0}; sampled at gnt
//  gnt        out  2      one-hot accept pulse, 1 cycle
//  rvalid     out  2      one-hot completion pulse (read data or write ack)
//  rdata      out  DW     read data, qualified by rvalid
//  err        out  2      misalignment error, coincident with rvalid
//  mem_re     out  1      memory read strobe
//  mem_we     out  1      memory write strobe (memory writes on the next clk edge)
//  mem_addr   out  AW     memory byte address
//  mem_wdata  out  DW     memory write data
//  mem_rdata  in   DW     memory read data, combinational from mem_addr/mem_re
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. RR pointer favours requester 0. lock_cnt = 0.
//  - FSM states: IDLE, ACCESS.
//    - IDLE: if any req, pick winner w. gnt[w]=1 (combinational, same cycle).
//      Capture w, we, lock, addr, wdata. Go to ACCESS.
//    - ACCESS: drive mem_re=~we_q or mem_we=we_q, mem_addr=addr_q, mem_wdata=wdata_q.
//      At the end of the cycle, capture mem_rdata (reads) and go to IDLE.
//    - Following cycle: rvalid[w]=1 for exactly 1 cycle. IDLE may grant again in this same cycle.
//  - Latency: gnt at T, strobe at T+1, rvalid at T+2. Peak throughput: 1 access / 2 cycles.
//  - Winner selection (in priority order):
//    1. Locked owner: if the previous grant had lock=1, its req is high, and lock_cnt < LOCK_MAX -> owner wins, lock_cnt++.
//    2. Otherwise round-robin: the requester not granted last wins when both request; a lone requester always wins.
//    - lock_cnt clears whenever ownership changes or a grant has lock=0.
//    - If lock_cnt reaches LOCK_MAX and the other requester waits, the other wins. If the other is idle, the owner keeps winning and lock_cnt saturates.
//  - Misaligned access (addr[1:0] != 0): still granted, but no strobe in ACCESS.
//    Completes at T+2 with rvalid, err=1, rdata=0. The RR pointer still updates.
//  - rdata holds its last read value across writes and idle cycles.
//    A write completion leaves rdata unchanged.
//  - req dropped before gnt: legal; nothing is issued.
//    req held after gnt: treated as a new request in the next IDLE.
//  - mem_addr is forwarded with byte address bits [1:0]=0; word indexing is owned by the memory.
//  - Reset mid-transaction (async): strobes and rvalid drop immediately. The pending access is discarded with no completion.
// STRUCTURE
//  - Package dmem_arb_pkg: state enum {IDLE, ACCESS}; requester index localparams REQ_CPU=0, REQ_DBG=1.
//  - Sub-module rr_lock_arb2: RR pointer, lock owner, lock_cnt; outputs one-hot winner.
//  - Top: FSM, capture registers, memory drive, response/err generation.
// TESTING
//  - Reset, then req=2'b01, we0=0, addr0=20 -> gnt0 @T, mem_re with mem_addr=20 @T+1, rvalid0 @T+2, rdata=mem_rdata sampled @T+1.
//  - req=2'b11 held, both reads, lock=0 -> grants alternate 0,1,0,1 every 2 cycles; never two gnt bits high at once.
//  - req0 write addr0=24 wdata0=47 -> mem_we=1 @T+1; a subsequent read of 24 returns 47; rdata is unchanged on the write rvalid.
//  - lock0=1 with req=2'b11, LOCK_MAX=4 -> 5 consecutive grants to 0 (initial + 4), then a grant to 1.
//  - addr1=6 (misaligned) -> gnt1, no mem_re/mem_we, rvalid1 and err1 @T+2, rdata=0.
//  - rst_n low during ACCESS -> mem_re/mem_we drop immediately, no rvalid; after release the first req=2'b11 is granted to 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM state type and requester indices for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;
endpackage

// File: rtl/dmem_arbiter_rr_lock_arb2.sv
// rr_lock_arb2: two-way round-robin arbiter with bounded lock ownership
module rr_lock_arb2 #(
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       fire,
  input  logic [1:0] lock,
  output logic [1:0] win,
  output logic       wi
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          last;
  logic          locked;
  logic [CW-1:0] cnt;
  logic          own_ok;
  logic          lock_w;
  logic          at_max;
  // locked owner first, then the requester not granted last, else the lone one
  always_comb begin
    at_max = cnt >= CW'(LOCK_MAX);
    own_ok = locked & req[last] & ~at_max;
    wi     = own_ok ? last : (&req ? ~last : req[1]);
    win    = fire ? (wi ? 2'b10 : 2'b01) : 2'b00;
    lock_w = lock[wi];
  end
  // pointer starts at requester 1 so requester 0 wins the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= 1'b1;
      locked <= 1'b0;
      cnt    <= '0;
    end else if (fire) begin
      last   <= wi;
      locked <= lock_w;
      cnt    <= (wi == last && locked && lock_w) ? (at_max ? cnt : cnt + 1'b1) : '0;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences two requesters onto a single-port data memory with fixed latency
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [1:0]      lock,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      err,
  output logic            mem_re,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  state_t        state;
  logic          fire;
  logic          wi;
  logic [1:0]    win;
  logic [AW-1:0] a_sel;
  logic [DW-1:0] d_sel;
  logic          we_sel;
  logic          mis;
  logic          w_q;
  logic          we_q;
  logic          mis_q;
  // select the winning requester's transaction fields
  always_comb begin
    fire   = (state == IDLE) & (|req);
    a_sel  = wi ? addr[2*AW-1:AW] : addr[AW-1:0];
    d_sel  = wi ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    we_sel = we[wi];
    mis    = |a_sel[1:0];
    gnt    = win;
  end
  rr_lock_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .fire  (fire),
    .lock  (lock),
    .win   (win),
    .wi    (wi)
  );
  // grant in IDLE, strobe memory in ACCESS, complete on the cycle after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= 1'b0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      rvalid    <= 2'b00;
      err       <= 2'b00;
      rdata     <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rvalid <= 2'b00;
      err    <= 2'b00;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      if (state == IDLE) begin
        if (fire) begin
          state     <= ACCESS;
          w_q       <= wi;
          we_q      <= we_sel;
          mis_q     <= mis;
          mem_re    <= ~we_sel & ~mis;
          mem_we    <= we_sel & ~mis;
          mem_addr  <= {a_sel[AW-1:2], 2'b00};
          mem_wdata <= d_sel;
        end
      end else begin
        state  <= IDLE;
        rvalid <= w_q ? 2'b10 : 2'b01;
        err    <= mis_q ? (w_q ? 2'b10 : 2'b01) : 2'b00;
        rdata  <= mis_q ? '0 : (we_q ? rdata : mem_rdata);
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for the data memory arbiter
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, we = '0, lock = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem [0:15];
  logic [35:0] exp_q [$];
  int          total = 0, bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? mem[mem_addr[5:2]] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [1:0] v, input logic [1:0] e, input logic [31:0] d);
    exp_q.push_back({v, e, d});
  endtask

  // scoreboard monitor: every completion must match the oldest expected response
  always @(negedge clk) begin
    if (rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rvalid", {62'h0, rvalid}, 64'h0);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("rvalid", {62'h0, rvalid}, {62'h0, e[35:34]});
        chk("err", {62'h0, err}, {62'h0, e[33:32]});
        chk("rdata", {32'h0, rdata}, {32'h0, e[31:0]});
      end
    end
  end

  // single access: grant now, check memory strobes one cycle later
  task automatic single(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic xre, input logic xwe,
                        input logic [31:0] xaddr, input logic [1:0] xerr, input logic [31:0] xdata);
    req = r; we = w; lock = 2'b00;
    addr = r[1] ? {a, 32'h0} : {32'h0, a};
    wdata = r[1] ? {d, 32'h0} : {32'h0, d};
    #1;
    chk("single_gnt", {62'h0, gnt}, {62'h0, r});
    expect_resp(r, xerr, xdata);
    tick;
    req = 2'b00;
    chk("single_mem_re", {63'h0, mem_re}, {63'h0, xre});
    chk("single_mem_we", {63'h0, mem_we}, {63'h0, xwe});
    if (xre | xwe) chk("single_mem_addr", {32'h0, mem_addr}, {32'h0, xaddr});
    if (xwe) chk("single_mem_wdata", {32'h0, mem_wdata}, {32'h0, d});
    tick;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd100 + 32'(i);
    #2;
    chk("reset_gnt", {62'h0, gnt}, 64'h0);
    chk("reset_rvalid", {62'h0, rvalid}, 64'h0);
    chk("reset_strobes", {62'h0, mem_re, mem_we}, 64'h0);
    chk("reset_rdata", {32'h0, rdata}, 64'h0);
    tick;
    rst_n = 1'b1;
    tick;
    // read of word 5
    single(2'b01, 2'b00, 32'd20, 32'd0, 1'b1, 1'b0, 32'd20, 2'b00, 32'd105);
    // both reading, last grant went to 0, so alternation starts at 1
    req = 2'b11; we = 2'b00; lock = 2'b00;
    addr = {32'd4, 32'd0};
    for (int i = 0; i < 8; i++) begin
      logic [1:0] g;
      g = (i % 2 != 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b10 : 2'b01);
      #1;
      chk("alt_gnt", {62'h0, gnt}, {62'h0, g});
      if (g != 2'b00) expect_resp(g, 2'b00, g[1] ? 32'd101 : 32'd100);
      tick;
    end
    req = 2'b00;
    tick;
    // write 47 to byte 24; rdata keeps the previous read value (100)
    single(2'b01, 2'b01, 32'd24, 32'd47, 1'b0, 1'b1, 32'd24, 2'b00, 32'd100);
    single(2'b01, 2'b00, 32'd24, 32'd0, 1'b1, 1'b0, 32'd24, 2'b00, 32'd47);
    // grant to 1 so that the locked run below begins with requester 0
    single(2'b10, 2'b00, 32'd8, 32'd0, 1'b1, 1'b0, 32'd8, 2'b00, 32'd102);
    req = 2'b11; we = 2'b00; lock = 2'b01;
    addr = {32'd4, 32'd0};
    for (int i = 0; i < 12; i++) begin
      logic [1:0] g;
      g = (i % 2 != 0) ? 2'b00 : ((i / 2 < 5) ? 2'b01 : 2'b10);
      #1;
      chk("lock_gnt", {62'h0, gnt}, {62'h0, g});
      if (g != 2'b00) expect_resp(g, 2'b00, g[1] ? 32'd101 : 32'd100);
      tick;
    end
    req = 2'b00; lock = 2'b00;
    tick;
    // misaligned byte address 6 from requester 1
    single(2'b10, 2'b00, 32'd6, 32'd0, 1'b0, 1'b0, 32'd0, 2'b10, 32'd0);
    // reset while the memory strobe is active: no completion may follow
    req = 2'b01; we = 2'b00; addr = {32'd0, 32'd0};
    #1;
    chk("rst_gnt", {62'h0, gnt}, 64'h1);
    tick;
    req = 2'b00;
    chk("rst_pre_mem_re", {63'h0, mem_re}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_re", {63'h0, mem_re}, 64'h0);
    chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
    chk("rst_rvalid", {62'h0, rvalid}, 64'h0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    req = 2'b11; addr = {32'd4, 32'd0};
    #1;
    chk("post_rst_gnt", {62'h0, gnt}, 64'h1);
    expect_resp(2'b01, 2'b00, 32'd100);
    tick;
    req = 2'b00;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick;
    tick;
    chk("drain", 64'(exp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
